// File: rtl/lsu_ctrl_if.sv
// Memory-side request/response bus of the load/store unit.
// master = LSU, slave = memory.
interface lsu_ctrl_if;
    logic        o_mem_valid;
    logic        i_mem_ready;
    logic [31:0] o_mem_addr;
    logic        o_mem_we;
    logic [3:0]  o_mem_wstrb;
    logic [31:0] o_mem_wdata;
    logic        i_mem_rvalid;
    logic [31:0] i_mem_rdata;

    modport master (
        output o_mem_valid, o_mem_addr, o_mem_we,
        output o_mem_wstrb, o_mem_wdata,
        input  i_mem_ready, i_mem_rvalid, i_mem_rdata
    );

    modport slave (
        input  o_mem_valid, o_mem_addr, o_mem_we,
        input  o_mem_wstrb, o_mem_wdata,
        output i_mem_ready, i_mem_rvalid, i_mem_rdata
    );
endinterface

// File: rtl/lsu_ctrl.sv
// RV32I load/store controller: one outstanding access,
// alignment/legality checks, lane steering and response timeout.
module lsu_ctrl #(
    parameter int unsigned WAIT_MAX = 255
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req,
    input  logic        i_we,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic        o_stall,
    output logic        o_done,
    output logic [31:0] o_rdata,
    output logic        o_err_misalign,
    output logic        o_err_timeout,
    lsu_ctrl_if.master  mem
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        RESP = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(WAIT_MAX - 1);

    state_t      state;
    logic        valid_q;
    logic        we_q;
    logic [2:0]  f3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [7:0]  cnt;

    logic        legal;
    logic        misal;
    logic [7:0]  ld_b;
    logic [15:0] ld_h;
    logic [31:0] ld_data;
    logic [3:0]  st_strb;
    logic [31:0] st_data;

    always_comb begin
        legal = 1'b0;
        misal = 1'b0;
        if (i_we)
            legal = i_funct3 inside {3'b000, 3'b001, 3'b010};
        else
            legal = i_funct3 inside {3'b000, 3'b001, 3'b010,
                                     3'b100, 3'b101};
        // funct3[1:0] encodes access size for every legal code
        unique case (i_funct3[1:0])
            2'b01:   misal = i_addr[0];
            2'b10:   misal = |i_addr[1:0];
            default: misal = 1'b0;
        endcase
    end

    always_comb begin
        ld_b    = mem.i_mem_rdata[{addr_q[1:0], 3'b000} +: 8];
        ld_h    = addr_q[1] ? mem.i_mem_rdata[31:16]
                            : mem.i_mem_rdata[15:0];
        ld_data = mem.i_mem_rdata;
        unique case (f3_q)
            3'b000:  ld_data = {{24{ld_b[7]}}, ld_b};
            3'b001:  ld_data = {{16{ld_h[15]}}, ld_h};
            3'b100:  ld_data = {24'd0, ld_b};
            3'b101:  ld_data = {16'd0, ld_h};
            default: ld_data = mem.i_mem_rdata;
        endcase
    end

    always_comb begin
        st_strb = 4'b1111;
        st_data = wdata_q;
        unique case (f3_q[1:0])
            2'b00: begin
                st_strb = 4'b0001 << addr_q[1:0];
                st_data = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                st_strb = 4'b0011 << {addr_q[1], 1'b0};
                st_data = {2{wdata_q[15:0]}};
            end
            default: begin
                st_strb = 4'b1111;
                st_data = wdata_q;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state          <= IDLE;
            valid_q        <= 1'b0;
            we_q           <= 1'b0;
            f3_q           <= 3'd0;
            addr_q         <= 32'd0;
            wdata_q        <= 32'd0;
            cnt            <= 8'd0;
            o_done         <= 1'b0;
            o_rdata        <= 32'd0;
            o_err_misalign <= 1'b0;
            o_err_timeout  <= 1'b0;
        end else begin
            o_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (i_req) begin
                        we_q           <= i_we;
                        f3_q           <= i_funct3;
                        addr_q         <= i_addr;
                        wdata_q        <= i_wdata;
                        o_rdata        <= 32'd0;
                        o_err_misalign <= 1'b0;
                        o_err_timeout  <= 1'b0;
                        if (legal && !misal) begin
                            state   <= ADDR;
                            valid_q <= 1'b1;
                        end else begin
                            state          <= DONE;
                            o_done         <= 1'b1;
                            o_err_misalign <= legal & misal;
                        end
                    end
                end
                ADDR: begin
                    if (mem.i_mem_ready) begin
                        valid_q <= 1'b0;
                        if (we_q) begin
                            state  <= DONE;
                            o_done <= 1'b1;
                        end else begin
                            state <= RESP;
                            cnt   <= 8'd0;
                        end
                    end
                end
                RESP: begin
                    if (mem.i_mem_rvalid) begin
                        state   <= DONE;
                        o_done  <= 1'b1;
                        o_rdata <= ld_data;
                    end else if (cnt == CNT_LAST) begin
                        state         <= DONE;
                        o_done        <= 1'b1;
                        o_err_timeout <= 1'b1;
                        o_rdata       <= 32'd0;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign o_stall = ((state == IDLE) & i_req)
                   | (state == ADDR)
                   | (state == RESP);

    assign mem.o_mem_valid = valid_q;
    assign mem.o_mem_addr  = valid_q ? {addr_q[31:2], 2'b00} : 32'd0;
    assign mem.o_mem_we    = valid_q & we_q;
    assign mem.o_mem_wstrb = (valid_q & we_q) ? st_strb : 4'd0;
    assign mem.o_mem_wdata = (valid_q & we_q) ? st_data : 32'd0;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: directed cases plus randomized accesses
// against an arithmetic reference model of RV32I load/store.
module tb_lsu_ctrl;

    localparam int WAIT_MAX = 4;

    logic        clk;
    logic        rst_n;
    logic        req;
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stall;
    logic        done;
    logic [31:0] rdata;
    logic        err_mis;
    logic        err_to;

    int total = 0;
    int bad   = 0;

    lsu_ctrl_if m ();

    lsu_ctrl #(.WAIT_MAX(WAIT_MAX)) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_req          (req),
        .i_we           (we),
        .i_funct3       (f3),
        .i_addr         (addr),
        .i_wdata        (wdata),
        .o_stall        (stall),
        .o_done         (done),
        .o_rdata        (rdata),
        .o_err_misalign (err_mis),
        .o_err_timeout  (err_to),
        .mem            (m)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // kind: 0 load, 1 store, 2 misaligned, 3 illegal
    function automatic void model(
        input  logic        mwe,
        input  logic [2:0]  mf3,
        input  logic [31:0] maddr,
        input  logic [31:0] mwd,
        input  logic [31:0] mword,
        output int          kind,
        output logic [31:0] rd,
        output logic [31:0] strb,
        output logic [31:0] wd
    );
        int size;
        int lane;
        logic [31:0] mask;
        logic [31:0] v;
        size = 1 << mf3[1:0];
        lane = int'(maddr[1:0]);
        rd   = 0;
        strb = 0;
        wd   = 0;
        if (mwe ? (mf3 > 3'd2) : !(mf3 inside {0, 1, 2, 4, 5})) begin
            kind = 3;
        end else if ((lane % size) != 0) begin
            kind = 2;
        end else if (mwe) begin
            kind = 1;
            strb = ((32'd1 << size) - 1) << lane;
            for (int i = 0; i < 4; i++)
                wd[8*i +: 8] = mwd[8*(i % size) +: 8];
        end else begin
            kind = 0;
            mask = (size == 4) ? 32'hFFFF_FFFF
                               : (32'd1 << (8 * size)) - 1;
            v = (mword >> (8 * lane)) & mask;
            if (!mf3[2] && size < 4 && v[8*size-1])
                v = v | ~mask;
            rd = v;
        end
    endfunction

    task automatic run_op(
        input  string       tag,
        input  logic        op_we,
        input  logic [2:0]  op_f3,
        input  logic [31:0] op_addr,
        input  logic [31:0] op_wd,
        input  logic [31:0] mword,
        input  int          rdy_dly,
        input  int          rv_dly,
        input  bit          give_rv,
        output logic [31:0] got_rd
    );
        int kind;
        int e_lat;
        int acc_cyc;
        int vcnt;
        bit seen_v;
        bit acc;
        bit fin;
        logic [31:0] e_rd;
        logic [31:0] e_strb;
        logic [31:0] e_wd;
        model(op_we, op_f3, op_addr, op_wd, mword,
              kind, e_rd, e_strb, e_wd);
        if (kind == 0)
            e_lat = give_rv ? 3 + rdy_dly + rv_dly
                            : 2 + rdy_dly + WAIT_MAX;
        else if (kind == 1)
            e_lat = 2 + rdy_dly;
        else
            e_lat = 1;
        if (kind == 0 && !give_rv)
            e_rd = 0;
        seen_v  = 0;
        acc     = 0;
        fin     = 0;
        acc_cyc = 0;
        vcnt    = 0;
        got_rd  = 'x;
        @(negedge clk);
        req   = 1'b1;
        we    = op_we;
        f3    = op_f3;
        addr  = op_addr;
        wdata = op_wd;
        for (int k = 0; k < 64 && !fin; k++) begin
            if (k > 0)
                @(negedge clk);
            if (acc && give_rv && k == acc_cyc + 1 + rv_dly) begin
                m.i_mem_rvalid = 1'b1;
                m.i_mem_rdata  = mword;
            end else if (!acc) begin
                m.i_mem_rvalid = 1'($urandom % 2);
                m.i_mem_rdata  = $urandom;
            end else begin
                m.i_mem_rvalid = 1'b0;
                m.i_mem_rdata  = $urandom;
            end
            if (m.o_mem_valid) begin
                seen_v = 1;
                chk({tag, ".maddr"}, m.o_mem_addr,
                    op_addr & 32'hFFFF_FFFC);
                chk({tag, ".mwe"}, 32'(m.o_mem_we), 32'(op_we));
                if (kind == 1) begin
                    chk({tag, ".strb"}, 32'(m.o_mem_wstrb), e_strb);
                    chk({tag, ".mwd"}, m.o_mem_wdata, e_wd);
                end
                m.i_mem_ready = (vcnt == rdy_dly);
                if (vcnt == rdy_dly) begin
                    acc     = 1;
                    acc_cyc = k;
                end
                vcnt++;
            end else begin
                chk({tag, ".idle_bus"},
                    m.o_mem_addr | m.o_mem_wdata
                    | 32'(m.o_mem_wstrb) | 32'(m.o_mem_we), 0);
                m.i_mem_ready = 1'($urandom % 2);
            end
            #1;
            if (done) begin
                fin    = 1;
                got_rd = rdata;
                chk({tag, ".lat"}, k, e_lat);
                chk({tag, ".mis"}, 32'(err_mis), 32'(kind == 2));
                chk({tag, ".to"}, 32'(err_to),
                    32'(kind == 0 && !give_rv));
                chk({tag, ".stall_done"}, 32'(stall), 0);
                if (kind == 0 || kind == 3)
                    chk({tag, ".rdata"}, rdata, e_rd);
            end else begin
                chk({tag, ".stall"}, 32'(stall), 1);
            end
        end
        chk({tag, ".finished"}, 32'(fin), 1);
        chk({tag, ".mem_used"}, 32'(seen_v), 32'(kind < 2));
        req            = 1'b0;
        m.i_mem_ready  = 1'b0;
        m.i_mem_rvalid = 1'b0;
        @(negedge clk);
        #1;
        chk({tag, ".done_pulse"}, 32'(done), 0);
        chk({tag, ".stall_after"}, 32'(stall), 0);
    endtask

    initial begin
        logic [31:0] r;
        rst_n          = 1'b0;
        req            = 1'b0;
        we             = 1'b0;
        f3             = 3'd0;
        addr           = 32'd0;
        wdata          = 32'd0;
        m.i_mem_ready  = 1'b0;
        m.i_mem_rvalid = 1'b0;
        m.i_mem_rdata  = 32'd0;
        repeat (3) @(negedge clk);
        chk("rst.done", 32'(done), 0);
        chk("rst.valid", 32'(m.o_mem_valid), 0);
        chk("rst.stall", 32'(stall), 0);
        chk("rst.rdata", rdata, 0);
        chk("rst.errs", {30'd0, err_mis, err_to}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst1.done", 32'(done), 0);
        chk("rst1.valid", 32'(m.o_mem_valid), 0);

        run_op("lb", 0, 3'b000, 32'h103, 0, 32'h80FF_1234,
               0, 0, 1, r);
        chk("lb.value", r, 32'hFFFF_FF80);
        run_op("sh", 1, 3'b001, 32'h202, 32'h0000_ABCD, 0,
               0, 0, 1, r);
        run_op("lw_mis", 0, 3'b010, 32'h101, 0, 0, 0, 0, 1, r);
        run_op("lhu", 0, 3'b101, 32'h2, 0, 32'hBEEF_0000,
               4, 1, 1, r);
        chk("lhu.value", r, 32'h0000_BEEF);
        run_op("lw_to", 0, 3'b010, 32'h40, 0, 32'h1234_5678,
               1, 0, 0, r);
        chk("lw_to.value", r, 0);
        run_op("lw_last", 0, 3'b010, 32'h44, 0, 32'hCAFE_F00D,
               0, WAIT_MAX - 1, 1, r);
        chk("lw_last.value", r, 32'hCAFE_F00D);
        run_op("ld_ill", 0, 3'b011, 32'h0, 0, 32'hFFFF_FFFF,
               0, 0, 1, r);
        run_op("st_ill", 1, 3'b100, 32'h0, 32'h55, 0, 0, 0, 1, r);
        run_op("sb", 1, 3'b000, 32'h31, 32'h1234_56A5, 0,
               2, 0, 1, r);
        run_op("sh_mis", 1, 3'b001, 32'h33, 32'h1, 0, 0, 0, 1, r);

        // reset in ADDR abandons the access
        @(negedge clk);
        req  = 1'b1;
        we   = 1'b0;
        f3   = 3'b010;
        addr = 32'h100;
        @(negedge clk);
        chk("rstaddr.valid_before", 32'(m.o_mem_valid), 1);
        req   = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        chk("rstaddr.valid", 32'(m.o_mem_valid), 0);
        chk("rstaddr.done", 32'(done), 0);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk("rstaddr.valid2", 32'(m.o_mem_valid), 0);
        chk("rstaddr.done2", 32'(done), 0);
        chk("rstaddr.stall2", 32'(stall), 0);
        run_op("after_rst", 0, 3'b100, 32'h102, 0, 32'h00F0_0000,
               0, 0, 1, r);
        chk("after_rst.value", r, 32'h0000_00F0);

        for (int n = 0; n < 80; n++) begin
            run_op("rnd", 1'($urandom % 2), 3'($urandom % 8),
                   32'($urandom % 4096), $urandom, $urandom,
                   int'($urandom % 4), int'($urandom % WAIT_MAX),
                   ($urandom % 6) != 0, r);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lsu_ctrl.md
LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 Parameter WAIT_MAX, default 255: maximum cycles spent in RESP before the response-timeout error is raised (range 1..255).
REQ-002 The block SHALL have one clock and a synchronous, active-low reset.
REQ-003 i_clk  in  1  clock; all state updates on the rising edge.
REQ-004 i_rst_n  in  1  synchronous active-low reset.
REQ-005 i_req  in  1  CPU memory-operation request; held, with the operands, until o_done.
REQ-006 i_we  in  1  1=store, 0=load.
REQ-007 i_funct3  in  3  RV32I width code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-008 i_addr  in  32  byte address.
REQ-009 i_wdata  in  32  store data, LSB-aligned.
REQ-010 o_stall  out  1  pipeline hold.
REQ-011 o_done  out  1  one-cycle completion pulse.
REQ-012 o_rdata  out  32  extended load result, valid while o_done=1.
REQ-013 o_err_misalign / o_err_timeout  out  1 each  error flags, valid while o_done=1.
REQ-014 o_mem_valid / i_mem_ready  out/in  1  memory request handshake.
REQ-015 o_mem_addr  out  32  word address ({addr[31:2],2'b00}).
REQ-016 o_mem_we, o_mem_wstrb[3:0], o_mem_wdata[31:0]  out  store controls and aligned data.
REQ-017 i_mem_rvalid / i_mem_rdata[31:0]  in  load response.

Function
REQ-018 FSM states: IDLE, ADDR, RESP, DONE; one access outstanding at most.
REQ-019 IDLE: i_req=1 latches we/funct3/addr/wdata; aligned and legal -> ADDR; otherwise -> DONE.
REQ-020 Misaligned: H/HU with addr[0]=1, or W with addr[1:0]!=0 -> DONE with o_err_misalign=1 and no memory request.
REQ-021 Illegal funct3 (loads 011/110/111; stores other than 000/001/010) -> DONE with no memory request, no error flag, and o_rdata=0.
REQ-022 ADDR: o_mem_valid=1 with address and controls stable until i_mem_ready=1; on ready a store goes to DONE and a load goes to RESP.
REQ-023 i_mem_rvalid outside RESP is ignored.
REQ-024 RESP: 8-bit counter cleared on entry and incremented each cycle.
REQ-025 RESP exit: i_mem_rvalid=1 latches extracted data and goes to DONE; if the counter reaches WAIT_MAX-1 without rvalid, go to DONE with o_err_timeout=1 and o_rdata=0.
REQ-026 Load extraction uses byte lane addr[1:0] and half lane addr[1]: B/H sign-extend, BU/HU zero-extend, W passes through.
REQ-027 Store strobes: SB 4'b0001<<addr[1:0] with byte replicated x4; SH 4'b0011<<{addr[1],1'b0} with half replicated x2; SW 4'b1111.
REQ-028 DONE lasts one cycle: o_done=1, then -> IDLE unconditionally; an i_req seen in IDLE on the next cycle starts a new access.
REQ-029 o_stall = (IDLE & i_req) | ADDR | RESP; o_stall=0 in DONE.
REQ-030 Latency with zero-wait memory: load o_done at cycle 3 after i_req; store at cycle 2; misaligned or illegal at cycle 1.
REQ-031 o_mem_* other than o_mem_valid are don't-care while o_mem_valid=0 and SHALL be driven 0.

Reset
REQ-032 When i_rst_n=0 at a clock edge: state<=IDLE, counter<=0, and all latched operands, o_rdata and error flags <=0.
REQ-033 o_mem_valid, o_done and o_stall are 0 in the first cycle after reset.
REQ-034 Reset asserted in ADDR or RESP abandons the access without a completion pulse.

Verification
REQ-035 LB addr=0x103, mem word 0x80FF_1234, zero-wait memory -> o_done at cycle 3 with o_rdata=0xFFFF_FF80 and no errors.
REQ-036 SH addr=0x202, wdata=0x0000_ABCD -> o_mem_wstrb=4'b1100, o_mem_wdata=0xABCD_ABCD, o_mem_addr=0x200, o_done at cycle 2.
REQ-037 LW addr=0x101 -> o_done at cycle 1 with o_err_misalign=1, and o_mem_valid never asserts.
REQ-038 LHU addr=0x2, i_mem_ready low for 4 cycles, rvalid 2 cycles later with 0xBEEF_0000 -> o_stall held throughout, then o_rdata=0x0000_BEEF.
REQ-039 Load with WAIT_MAX=4 and no rvalid -> o_done 4 cycles after RESP entry with o_err_timeout=1 and o_rdata=0.
REQ-040 Reset pulsed during ADDR -> FSM returns to IDLE, and o_mem_valid=0 and o_done=0 on the following cycle.
